// File: rtl/fir_mac_filter.sv
// Sequential multiply-accumulate FIR stage: one multiplier, TAPS+1 clocks per sample.
// Optional output clamp is built when FIR_SATURATE_EN is defined; otherwise the result wraps.
//
// state | meaning
// IDLE  | waiting for sample_valid; coefficient writes accepted
// MAC   | one tap per clock: acc += d[idx] * c[idx]
// ROUND | round, limit and register out_data, pulse out_valid
module fir_mac_filter #(
    parameter int                 TAPS       = 16,
    parameter logic signed [15:0] COEF_RESET = 16'sd2048
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_valid,
    input  logic [11:0]             sample_in,
    input  logic                    coef_we,
    input  logic [$clog2(TAPS)-1:0] coef_addr,
    input  logic [15:0]             coef_data,
    output logic                    out_valid,
    output logic [11:0]             out_data,
    output logic                    busy,
    output logic                    overrun
);

    localparam int AW   = $clog2(TAPS);
    localparam int ACCW = 28 + AW;
    localparam logic signed [ACCW-1:0] HALF = ACCW'(16384);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        ROUND
    } state_t;

    state_t                 state;
    logic signed [11:0]     dly  [TAPS];
    logic signed [15:0]     coef [TAPS];
    logic [AW-1:0]          idx;
    logic signed [ACCW-1:0] acc;

    logic signed [11:0]     x_in;
    logic signed [27:0]     d_ext;
    logic signed [27:0]     c_ext;
    logic signed [27:0]     prod;
    logic signed [ACCW-1:0] acc_next;
    logic signed [ACCW-1:0] rnd_sum;
    logic signed [ACCW-1:0] rnd;
    logic [11:0]            r12;

    // Offset-binary ADC code to two's complement: invert the MSB.
    assign x_in = {~sample_in[11], sample_in[10:0]};

    assign d_ext    = {{16{dly[idx][11]}}, dly[idx]};
    assign c_ext    = {{12{coef[idx][15]}}, coef[idx]};
    assign prod     = d_ext * c_ext;
    assign acc_next = acc + {{AW{prod[27]}}, prod};

    assign rnd_sum = acc + HALF;
    assign rnd     = rnd_sum >>> 15;

`ifdef FIR_SATURATE_EN
    localparam logic signed [ACCW-1:0] R_MAX = ACCW'(2047);
    localparam logic signed [ACCW-1:0] R_MIN = ACCW'(-2048);

    always_comb begin
        r12 = rnd[11:0];
        if (rnd > R_MAX) begin
            r12 = 12'h7FF;
        end else if (rnd < R_MIN) begin
            r12 = 12'h800;
        end
    end
`else
    logic unused_rnd;

    // Upper bits are discarded on purpose: two's-complement wrap.
    assign r12        = rnd[11:0];
    assign unused_rnd = ^rnd[ACCW-1:12];
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            acc       <= '0;
            out_data  <= 12'h800;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                dly[k]  <= '0;
                coef[k] <= COEF_RESET;
            end
        end else begin
            out_valid <= 1'b0;
            if ((state != IDLE) && (sample_valid || coef_we)) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (coef_we) begin
                        coef[coef_addr] <= coef_data;
                    end
                    if (sample_valid) begin
                        dly[0] <= x_in;
                        for (int k = 1; k < TAPS; k++) begin
                            dly[k] <= dly[k-1];
                        end
                        acc   <= '0;
                        idx   <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    idx <= idx + AW'(1);
                    if (idx == AW'(TAPS - 1)) begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    out_data  <= {~r12[11], r12[10:0]};
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_filter.sv
// Scoreboard bench for fir_mac_filter: reference model computes each expected output
// from the sample history and coefficient table with plain integer arithmetic.
module tb_fir_mac_filter;

    localparam int TAPS = 16;
    localparam int AW   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          sample_valid;
    logic [11:0]   sample_in;
    logic          coef_we;
    logic [AW-1:0] coef_addr;
    logic [15:0]   coef_data;
    logic          out_valid;
    logic [11:0]   out_data;
    logic          busy;
    logic          overrun;

    fir_mac_filter dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .coef_we      (coef_we),
        .coef_addr    (coef_addr),
        .coef_data    (coef_data),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [11:0] data;
        int          p;
    } exp_t;

    exp_t sbq[$];
    int   hist[TAPS];
    int   coef_m[TAPS];
    int   last_acc;
    bit   m_ov;
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: y = round(sum x[n-k]*c[k] / 2^15), limited to 12 bits, back to offset binary.
    function automatic logic [11:0] model_out();
        longint s = 0;
        longint r;
        logic [11:0] r12;
        for (int k = 0; k < TAPS; k++) s += longint'(hist[k]) * longint'(coef_m[k]);
        r = (s + 16384) >>> 15;
`ifdef FIR_SATURATE_EN
        if (r > 2047) r = 2047;
        if (r < -2048) r = -2048;
`endif
        r12 = 12'(r);
        return r12 ^ 12'h800;
    endfunction

    task automatic model_reset();
        sbq.delete();
        for (int k = 0; k < TAPS; k++) begin
            hist[k]   = 0;
            coef_m[k] = 2048;
        end
        last_acc = -1000;
        m_ov     = 0;
    endtask

    // Model of one clock edge p; the engine is free once TAPS+2 edges have passed.
    task automatic model_edge(input int p, input bit sv, input logic [11:0] sd,
                              input bit we, input logic [AW-1:0] a, input logic [15:0] cd);
        bit idle;
        idle = (p >= last_acc + TAPS + 2);
        if (we) begin
            if (idle) coef_m[a] = int'($signed(cd));
            else m_ov = 1;
        end
        if (sv) begin
            if (idle) begin
                for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = int'(sd) - 2048;
                sbq.push_back('{model_out(), p});
                last_acc = p;
            end else begin
                m_ov = 1;
            end
        end
    endtask

    task automatic drive(input bit sv, input logic [11:0] sd, input bit we,
                         input logic [AW-1:0] a, input logic [15:0] cd);
        sample_valid = sv;
        sample_in    = sd;
        coef_we      = we;
        coef_addr    = a;
        coef_data    = cd;
        model_edge(cyc + 1, sv, sd, we, a, cd);
        @(negedge clk);
        sample_valid = 1'b0;
        coef_we      = 1'b0;
    endtask

    task automatic wait_drain();
        int budget = 0;
        while (sbq.size() != 0 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        chk("drain_timeout", sbq.size(), 0);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            pulses++;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid actual=%0h required=none", out_data);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("out_data", out_data, e.data);
                chk("latency", cyc - e.p, TAPS + 1);
                chk("busy_at_valid", busy, 0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int p0;
        bit any_b;
        bit any_o;
        rst          = 1'b1;
        sample_valid = 1'b0;
        sample_in    = '0;
        coef_we      = 1'b0;
        coef_addr    = '0;
        coef_data    = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Quiet after reset
        p0 = pulses;
        any_b = 0;
        any_o = 0;
        repeat (100) begin
            @(negedge clk);
            if (busy) any_b = 1;
            if (overrun) any_o = 1;
        end
        chk("reset_out_data", out_data, 12'h800);
        chk("reset_busy", any_b, 0);
        chk("reset_overrun", any_o, 0);
        chk("reset_no_valid", pulses - p0, 0);

        // Default moving average, full-scale step
        for (int i = 0; i < 16; i++) begin
            drive(1, 12'hFFF, 0, 0, 0);
            if (i == 0) chk("busy_after_accept", busy, 1);
            repeat (17) @(negedge clk);
            if (i == 0 || i == 15) begin
                chk("step_valid", out_valid, 1);
                chk("step_value", out_data, (i == 0) ? 12'h880 : 12'hFFF);
            end
            repeat (82) @(negedge clk);
        end

        // Single-tap impulse
        drive(0, 0, 1, 0, 16'h7FFF);
        for (int k = 1; k < TAPS; k++) drive(0, 0, 1, AW'(k), 16'h0000);
        drive(1, 12'hFFF, 0, 0, 0);
        repeat (20) @(negedge clk);
        chk("impulse_hi", out_data, 12'hFFF);
        drive(1, 12'h800, 0, 0, 0);
        repeat (20) @(negedge clk);
        chk("impulse_mid", out_data, 12'h800);

        // Rejected sample and coefficient write while busy
        chk("overrun_before", overrun, 0);
        p0 = pulses;
        drive(1, 12'h123, 0, 0, 0);
        repeat (4) @(negedge clk);
        drive(1, 12'h456, 0, 0, 0);
        repeat (2) @(negedge clk);
        drive(0, 0, 1, 0, 16'h0000);
        wait_drain();
        repeat (5) @(negedge clk);
        chk("overrun_one_valid", pulses - p0, 1);
        chk("overrun_set", overrun, 1);
        drive(1, 12'hABC, 0, 0, 0);
        wait_drain();
        chk("coef_kept", out_data, 12'hABC);
        drive(0, 0, 1, 0, 16'h0000);
        drive(0, 0, 1, 2, 16'h7FFF);
        drive(1, 12'h111, 0, 0, 0);
        wait_drain();
        chk("delay_advanced_once", out_data, 12'h123);

        // All taps at maximum gain
        for (int k = 0; k < TAPS; k++) drive(0, 0, 1, AW'(k), 16'h7FFF);
        for (int i = 0; i < 16; i++) begin
            drive(1, 12'hFFF, 0, 0, 0);
            repeat (19) @(negedge clk);
        end
        wait_drain();
`ifdef FIR_SATURATE_EN
        chk("max_gain", out_data, 12'hFFF);
`else
        chk("max_gain", out_data, 12'h7EF);
`endif

        // Reset in the middle of a convolution
        drive(1, 12'h321, 0, 0, 0);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        p0 = pulses;
        repeat (30) @(negedge clk);
        chk("abort_no_valid", pulses - p0, 0);
        chk("abort_out_data", out_data, 12'h800);
        chk("abort_busy", busy, 0);
        chk("abort_overrun", overrun, 0);
        drive(1, 12'hFFF, 0, 0, 0);
        repeat (20) @(negedge clk);
        chk("after_abort", out_data, 12'h880);

        // Random samples, coefficient writes and spacing, some inside the busy window
        for (int i = 0; i < 80; i++) begin
            int gap;
            bit sv;
            bit we;
            gap = $urandom_range(2, 30);
            repeat (gap - 1) @(negedge clk);
            sv = ($urandom_range(0, 9) < 7);
            we = ($urandom_range(0, 9) < 3);
            drive(sv, 12'($urandom), we, AW'($urandom), 16'($urandom));
        end
        wait_drain();
        chk("random_overrun", overrun, m_ov);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
